// File: rtl/tape_out_capture.sv
// tape_out_capture
//   Recovers Oric cassette bytes from the K7_TAPEOUT waveform. The period
//   between rising edges of tape_in is measured on clk and classified as a
//   1 bit, a 0 bit, a glitch or a timeout. Bits are framed as Oric bytes
//   (start 0, 8 data bits LSB first, odd parity, stop 1s) and completed
//   bytes are queued in a first-word-fall-through FIFO for the HPS upload.
//
// Configuration macro:
//   TAPE_CAPTURE_PARITY_EN - when defined, the parity bit is checked and a
//   failure sets parity_err. When undefined, the parity bit is still
//   consumed (framing is unchanged) and parity_err is tied to 0.
//
// Ports:
//   clk        in   system clock (clk_sys)
//   reset      in   asynchronous active-high reset
//   enable     in   capture enable; low holds the framer in IDLE
//   tape_in    in   raw tape level, asynchronous to clk
//   rd         in   pop the FIFO head (ignored when empty)
//   dout       out  FIFO head byte, valid while empty is 0
//   empty      out  FIFO empty
//   level      out  FIFO occupancy
//   byte_cnt   out  bytes decoded since reset/clear, wraps
//   parity_err out  sticky parity failure
//   overflow   out  sticky dropped-byte flag
//   active     out  framer is not in IDLE
//   clr_flags  in   synchronous clear of parity_err, overflow and byte_cnt
module tape_out_capture #(
  parameter int unsigned MIN_PERIOD = 4000,
  parameter int unsigned THRESH     = 12500,
  parameter int unsigned MAX_PERIOD = 40000,
  parameter int unsigned FIFO_AW    = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic               tape_in,
  input  logic               rd,
  output logic [7:0]         dout,
  output logic               empty,
  output logic [FIFO_AW:0]   level,
  output logic [15:0]        byte_cnt,
  output logic               parity_err,
  output logic               overflow,
  output logic               active,
  input  logic               clr_flags
);

  localparam logic [15:0] MIN_P = 16'(MIN_PERIOD);
  localparam logic [15:0] THR_P = 16'(THRESH);
  localparam logic [15:0] MAX_P = 16'(MAX_PERIOD);
  localparam logic [15:0] TMO_P = 16'(MAX_PERIOD + 1);

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY} state_t;

  logic sync1_q, sync1_d, sync2_q, sync2_d, lvl_q, lvl_d, edge_q, edge_d;
  logic [15:0] per_q, per_d;
  state_t state_q, state_d;
  logic [2:0] idx_q, idx_d;
  logic [7:0] shreg_q, shreg_d;
  logic [FIFO_AW:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [15:0] byte_cnt_q, byte_cnt_d;
  logic ovf_q, ovf_d;
  logic [7:0] mem [0:(1 << FIFO_AW) - 1];

  logic is_glitch, is_tmo, bit_vld, bit_val, force_idle;
  logic push_req, full, fifo_empty, do_pop, do_push;

  // Synchronizer, edge register and period counter
  always_comb begin
    sync1_d = tape_in;
    sync2_d = sync1_q;
    lvl_d   = sync2_q;
    edge_d  = sync2_q & ~lvl_q;

    is_glitch = (per_q < MIN_P);
    is_tmo    = (per_q > MAX_P);
    bit_vld   = edge_q && !is_glitch && !is_tmo;
    bit_val   = (per_q < THR_P);

    // Glitch edges leave the counter running so the real period survives.
    per_d = per_q;
    if (edge_q && !is_glitch) per_d = 16'd1;
    else if (per_q != 16'hFFFF) per_d = per_q + 16'd1;

    force_idle = !enable || (edge_q && is_tmo) || (per_q == TMO_P);
  end

  // Framer
`ifdef TAPE_CAPTURE_PARITY_EN
  logic par_bad;
  logic perr_q, perr_d;
`endif

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    shreg_d  = shreg_q;
    push_req = 1'b0;
`ifdef TAPE_CAPTURE_PARITY_EN
    par_bad  = 1'b0;
`endif
    if (force_idle) begin
      state_d = S_IDLE;
    end else if (bit_vld) begin
      unique case (state_q)
        S_IDLE: begin
          if (!bit_val) begin
            state_d = S_DATA;
            idx_d   = 3'd0;
          end
        end
        S_DATA: begin
          shreg_d = {bit_val, shreg_q[7:1]};
          idx_d   = idx_q + 3'd1;
          if (idx_q == 3'd7) state_d = S_PARITY;
        end
        S_PARITY: begin
          push_req = 1'b1;
`ifdef TAPE_CAPTURE_PARITY_EN
          // Odd parity: data ones plus the parity bit must be odd.
          par_bad  = ~(^shreg_q ^ bit_val);
`endif
          state_d  = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // FIFO and status
  always_comb begin
    fifo_empty = (wr_ptr_q == rd_ptr_q);
    full       = (wr_ptr_q[FIFO_AW] != rd_ptr_q[FIFO_AW]) &&
                 (wr_ptr_q[FIFO_AW-1:0] == rd_ptr_q[FIFO_AW-1:0]);
    do_pop     = rd && !fifo_empty;
    // A pop in the same cycle frees the slot the full-FIFO push lands in.
    do_push    = push_req && (!full || do_pop);

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;

    // A push in the same cycle as clr_flags leaves the count at 1.
    byte_cnt_d = byte_cnt_q;
    if (push_req) byte_cnt_d = clr_flags ? 16'd1 : byte_cnt_q + 16'd1;
    else if (clr_flags) byte_cnt_d = 16'd0;

    ovf_d = clr_flags ? 1'b0 : ovf_q;
    if (push_req && full && !do_pop) ovf_d = 1'b1;

`ifdef TAPE_CAPTURE_PARITY_EN
    perr_d = clr_flags ? 1'b0 : perr_q;
    if (par_bad) perr_d = 1'b1;
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      lvl_q      <= 1'b0;
      edge_q     <= 1'b0;
      per_q      <= 16'hFFFF;
      state_q    <= S_IDLE;
      idx_q      <= 3'd0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      byte_cnt_q <= 16'd0;
      ovf_q      <= 1'b0;
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      lvl_q      <= lvl_d;
      edge_q     <= edge_d;
      per_q      <= per_d;
      state_q    <= state_d;
      idx_q      <= idx_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      byte_cnt_q <= byte_cnt_d;
      ovf_q      <= ovf_d;
    end
  end

`ifdef TAPE_CAPTURE_PARITY_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) perr_q <= 1'b0;
    else       perr_q <= perr_d;
  end
  assign parity_err = perr_q;
`else
  assign parity_err = 1'b0;
`endif

  // Data-only storage: contents are meaningless until framed/pushed.
  always_ff @(posedge clk) begin
    shreg_q <= shreg_d;
    if (do_push) mem[wr_ptr_q[FIFO_AW-1:0]] <= shreg_q;
  end

  assign dout     = fifo_empty ? 8'h00 : mem[rd_ptr_q[FIFO_AW-1:0]];
  assign empty    = fifo_empty;
  assign level    = wr_ptr_q - rd_ptr_q;
  assign byte_cnt = byte_cnt_q;
  assign overflow = ovf_q;
  assign active   = (state_q != S_IDLE);

endmodule

// File: tb/tb_tape_out_capture.sv
// Testbench for tape_out_capture: synthesises tape waveforms from byte
// frames and compares the DUT against a frame-level queue model.
module tb_tape_out_capture;
  localparam int AW = 2;
`ifdef TAPE_CAPTURE_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset, enable, tape_in, rd, clr_flags;
  logic [7:0] dout;
  logic empty;
  logic [AW:0] level;
  logic [15:0] byte_cnt;
  logic parity_err, overflow, active;

  int n_checks = 0;
  int n_pass = 0;

  logic [7:0] exp_q[$];
  int unsigned exp_cnt = 0;
  bit exp_perr = 0;
  bit exp_ovf = 0;

  tape_out_capture #(.MIN_PERIOD(4), .THRESH(12), .MAX_PERIOD(24), .FIFO_AW(AW)) dut (
    .clk(clk), .reset(reset), .enable(enable), .tape_in(tape_in), .rd(rd),
    .dout(dout), .empty(empty), .level(level), .byte_cnt(byte_cnt),
    .parity_err(parity_err), .overflow(overflow), .active(active),
    .clr_flags(clr_flags)
  );

  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One tape period of p clocks starting with a rising edge.
  task automatic send_period(input int p, input bit rd_pulse, input bit glitch);
    int h;
    h = p / 2;
    for (int i = 0; i < p; i++) begin
      tape_in = glitch ? ((i == 0) || (i >= 3 && i < h)) : (i < h);
      if (rd_pulse && i == 3) rd = 1'b1;
      if (rd_pulse && i == 4) rd = 1'b0;
      tick();
    end
  endtask

  task automatic idle_gap(input int n);
    tape_in = 1'b0;
    repeat (n) tick();
  endtask

  function automatic int one_len(input int mode);
    if (mode == 1) return int'($urandom_range(11, 4));
    if (mode == 2) return ($urandom_range(1, 0) != 0) ? 4 : 11;
    return 8;
  endfunction

  function automatic int zero_len(input int mode);
    if (mode == 1) return int'($urandom_range(24, 12));
    if (mode == 2) return ($urandom_range(1, 0) != 0) ? 12 : 24;
    return 16;
  endfunction

  // Frame-level reference: what the upload side should see after a byte.
  task automatic model_push(input logic [7:0] b, input bit par, input bit rd_sim);
    exp_cnt++;
    if (PAR_EN && ((($countones(b) + int'(par)) % 2) == 0)) exp_perr = 1'b1;
    if (rd_sim && exp_q.size() > 0) void'(exp_q.pop_front());
    if (exp_q.size() < 4) exp_q.push_back(b);
    else exp_ovf = 1'b1;
  endtask

  task automatic model_clear_flags();
    exp_cnt = 0;
    exp_perr = 1'b0;
    exp_ovf = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit par, input int lead, input int mode,
                            input bit glitch, input bit rd_sim, input bit expect_push);
    for (int i = 0; i < lead; i++) send_period(one_len(mode), 1'b0, 1'b0);
    send_period(zero_len(mode), 1'b0, glitch);
    for (int i = 0; i < 8; i++)
      send_period(b[i] ? one_len(mode) : zero_len(mode), 1'b0, glitch && !b[i]);
    send_period(par ? one_len(mode) : zero_len(mode), 1'b0, glitch && !par);
    send_period(8, rd_sim, 1'b0);
    idle_gap(30);
    if (expect_push) model_push(b, par, rd_sim);
  endtask

  task automatic do_read();
    rd = 1'b1;
    tick();
    rd = 1'b0;
    if (exp_q.size() > 0) void'(exp_q.pop_front());
  endtask

  task automatic pulse_clr();
    clr_flags = 1'b1;
    tick();
    clr_flags = 1'b0;
    model_clear_flags();
  endtask

  task automatic test_reset();
    reset = 1'b1; enable = 1'b0; tape_in = 1'b0; rd = 1'b0; clr_flags = 1'b0;
    repeat (3) tick();
    n_checks++; if (dout !== 8'h00) $display("FAIL rst_dout got %h exp 00", dout); else n_pass++;
    n_checks++; if (empty !== 1'b1) $display("FAIL rst_empty got %b exp 1", empty); else n_pass++;
    n_checks++; if (level !== 3'd0) $display("FAIL rst_level got %0d exp 0", level); else n_pass++;
    n_checks++; if (byte_cnt !== 16'd0) $display("FAIL rst_byte_cnt got %0d exp 0", byte_cnt); else n_pass++;
    n_checks++; if (parity_err !== 1'b0) $display("FAIL rst_parity_err got %b exp 0", parity_err); else n_pass++;
    n_checks++; if (overflow !== 1'b0) $display("FAIL rst_overflow got %b exp 0", overflow); else n_pass++;
    n_checks++; if (active !== 1'b0) $display("FAIL rst_active got %b exp 0", active); else n_pass++;
    reset = 1'b0;
    enable = 1'b1;
    repeat (2) tick();
  endtask

  task automatic test_single_byte();
    send_frame(8'hA5, 1'b1, 3, 0, 1'b0, 1'b0, 1'b1);
    n_checks++; if (dout !== 8'hA5) $display("FAIL single_dout got %h exp a5", dout); else n_pass++;
    n_checks++; if (empty !== 1'b0) $display("FAIL single_empty got %b exp 0", empty); else n_pass++;
    n_checks++; if (byte_cnt !== 16'd1) $display("FAIL single_byte_cnt got %0d exp 1", byte_cnt); else n_pass++;
    n_checks++; if (parity_err !== 1'b0) $display("FAIL single_parity_err got %b exp 0", parity_err); else n_pass++;
    do_read();
    n_checks++; if (empty !== 1'b1) $display("FAIL single_empty_after_rd got %b exp 1", empty); else n_pass++;
    n_checks++; if (level !== 3'd0) $display("FAIL single_level_after_rd got %0d exp 0", level); else n_pass++;
  endtask

  task automatic test_parity_err();
    send_frame(8'hA5, 1'b0, 2, 0, 1'b0, 1'b0, 1'b1);
    n_checks++; if (dout !== 8'hA5) $display("FAIL perr_dout got %h exp a5", dout); else n_pass++;
    n_checks++; if (parity_err !== exp_perr) $display("FAIL perr_flag got %b exp %b", parity_err, exp_perr); else n_pass++;
    n_checks++; if (byte_cnt !== 16'd2) $display("FAIL perr_byte_cnt got %0d exp 2", byte_cnt); else n_pass++;
    pulse_clr();
    n_checks++; if (parity_err !== 1'b0) $display("FAIL perr_clr_flag got %b exp 0", parity_err); else n_pass++;
    n_checks++; if (byte_cnt !== 16'd0) $display("FAIL perr_clr_byte_cnt got %0d exp 0", byte_cnt); else n_pass++;
    do_read();
  endtask

  task automatic test_glitch();
    send_frame(8'hA5, 1'b1, 2, 0, 1'b1, 1'b0, 1'b1);
    n_checks++; if (dout !== 8'hA5) $display("FAIL glitch_dout got %h exp a5", dout); else n_pass++;
    n_checks++; if (level !== 3'd1) $display("FAIL glitch_level got %0d exp 1", level); else n_pass++;
    n_checks++; if (parity_err !== 1'b0) $display("FAIL glitch_parity_err got %b exp 0", parity_err); else n_pass++;
    do_read();
  endtask

  task automatic test_timeout();
    logic [7:0] b;
    b = 8'h3C;
    send_period(8, 1'b0, 1'b0);
    send_period(8, 1'b0, 1'b0);
    send_period(16, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      send_period(b[i] ? 8 : 16, 1'b0, 1'b0);
      if (i == 1) begin
        n_checks++; if (active !== 1'b1) $display("FAIL tmo_active_mid got %b exp 1", active); else n_pass++;
      end
    end
    idle_gap(30);
    n_checks++; if (active !== 1'b0) $display("FAIL tmo_active got %b exp 0", active); else n_pass++;
    n_checks++; if (level !== 3'd0) $display("FAIL tmo_level got %0d exp 0", level); else n_pass++;
    n_checks++; if (byte_cnt !== 16'(exp_cnt)) $display("FAIL tmo_byte_cnt got %0d exp %0d", byte_cnt, exp_cnt); else n_pass++;
    send_frame(8'h3C, 1'b1, 2, 0, 1'b0, 1'b0, 1'b1);
    n_checks++; if (dout !== 8'h3C) $display("FAIL tmo_next_dout got %h exp 3c", dout); else n_pass++;
    n_checks++; if (byte_cnt !== 16'(exp_cnt)) $display("FAIL tmo_next_byte_cnt got %0d exp %0d", byte_cnt, exp_cnt); else n_pass++;
    do_read();
  endtask

  task automatic test_enable_low();
    enable = 1'b0;
    send_frame(8'h77, 1'b0, 2, 0, 1'b0, 1'b0, 1'b0);
    n_checks++; if (level !== 3'd0) $display("FAIL en_level got %0d exp 0", level); else n_pass++;
    n_checks++; if (byte_cnt !== 16'(exp_cnt)) $display("FAIL en_byte_cnt got %0d exp %0d", byte_cnt, exp_cnt); else n_pass++;
    n_checks++; if (active !== 1'b0) $display("FAIL en_active got %b exp 0", active); else n_pass++;
    enable = 1'b1;
  endtask

  task automatic test_random();
    logic [7:0] b;
    bit par;
    pulse_clr();
    for (int k = 0; k < 12; k++) begin
      b = 8'($urandom_range(255, 0));
      par = ($urandom_range(3, 0) != 0) ? ~^b : ^b;
      send_frame(b, par, int'($urandom_range(3, 1)), (k % 2) + 1, 1'b0, 1'b0, 1'b1);
      n_checks++; if (dout !== exp_q[0]) $display("FAIL rnd_dout[%0d] got %h exp %h", k, dout, exp_q[0]); else n_pass++;
      n_checks++; if (level !== 3'(exp_q.size())) $display("FAIL rnd_level[%0d] got %0d exp %0d", k, level, exp_q.size()); else n_pass++;
      n_checks++; if (byte_cnt !== 16'(exp_cnt)) $display("FAIL rnd_byte_cnt[%0d] got %0d exp %0d", k, byte_cnt, exp_cnt); else n_pass++;
      n_checks++; if (parity_err !== exp_perr) $display("FAIL rnd_parity_err[%0d] got %b exp %b", k, parity_err, exp_perr); else n_pass++;
      do_read();
    end
  endtask

  task automatic test_overflow();
    logic [7:0] b;
    pulse_clr();
    for (int k = 1; k <= 5; k++) begin
      b = 8'(k);
      send_frame(b, ~^b, 1, 0, 1'b0, 1'b0, 1'b1);
    end
    n_checks++; if (level !== 3'd4) $display("FAIL ovf_level got %0d exp 4", level); else n_pass++;
    n_checks++; if (overflow !== 1'b1) $display("FAIL ovf_flag got %b exp 1", overflow); else n_pass++;
    n_checks++; if (byte_cnt !== 16'd5) $display("FAIL ovf_byte_cnt got %0d exp 5", byte_cnt); else n_pass++;
    for (int k = 1; k <= 4; k++) begin
      n_checks++; if (dout !== 8'(k)) $display("FAIL ovf_read[%0d] got %h exp %h", k, dout, 8'(k)); else n_pass++;
      do_read();
    end
    n_checks++; if (empty !== 1'b1) $display("FAIL ovf_empty got %b exp 1", empty); else n_pass++;
  endtask

  task automatic test_full_rd();
    logic [7:0] b;
    pulse_clr();
    for (int k = 0; k < 4; k++) begin
      b = 8'h11 + 8'(k);
      send_frame(b, ~^b, 1, 1, 1'b0, 1'b0, 1'b1);
    end
    b = 8'h9E;
    send_frame(b, ~^b, 2, 0, 1'b0, 1'b1, 1'b1);
    n_checks++; if (level !== 3'd4) $display("FAIL fullrd_level got %0d exp 4", level); else n_pass++;
    n_checks++; if (overflow !== 1'b0) $display("FAIL fullrd_overflow got %b exp 0", overflow); else n_pass++;
    n_checks++; if (byte_cnt !== 16'd5) $display("FAIL fullrd_byte_cnt got %0d exp 5", byte_cnt); else n_pass++;
    for (int k = 0; k < 4; k++) begin
      n_checks++; if (dout !== exp_q[0]) $display("FAIL fullrd_read[%0d] got %h exp %h", k, dout, exp_q[0]); else n_pass++;
      if (k == 3) begin
        n_checks++; if (dout !== 8'h9E) $display("FAIL fullrd_tail got %h exp 9e", dout); else n_pass++;
      end
      do_read();
    end
  endtask

  task automatic test_reset_mid();
    send_frame(8'h42, ~^8'h42, 1, 0, 1'b0, 1'b0, 1'b1);
    send_period(8, 1'b0, 1'b0);
    send_period(16, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) send_period(16, 1'b0, 1'b0);
    n_checks++; if (active !== 1'b1) $display("FAIL rmid_active_before got %b exp 1", active); else n_pass++;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    exp_q.delete();
    model_clear_flags();
    n_checks++; if (active !== 1'b0) $display("FAIL rmid_active got %b exp 0", active); else n_pass++;
    n_checks++; if (empty !== 1'b1) $display("FAIL rmid_empty got %b exp 1", empty); else n_pass++;
    n_checks++; if (byte_cnt !== 16'd0) $display("FAIL rmid_byte_cnt got %0d exp 0", byte_cnt); else n_pass++;
    idle_gap(30);
    send_frame(8'hC3, ~^8'hC3, 2, 0, 1'b0, 1'b0, 1'b1);
    n_checks++; if (dout !== 8'hC3) $display("FAIL rmid_next_dout got %h exp c3", dout); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_parity_err();
    test_glitch();
    test_timeout();
    test_enable_low();
    test_random();
    test_overflow();
    test_full_rd();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/tape_out_capture.md
# tape_out_capture

Decodes the Oric cassette output waveform (`K7_TAPEOUT`) back into bytes, the reverse of the TAP loader path. It measures the period between rising edges, classifies each period as a 0 bit, a 1 bit or noise, and frames the bits into Oric bytes. Completed bytes are buffered in a small first-word-fall-through FIFO that an HPS upload path drains to build a TAP file. It sits in the top level beside the cassette loader, on `clk_sys`, with its input taken from `tape_out`.

## Interface

Parameters:
- `MIN_PERIOD`, 4000: periods shorter than this many clocks are treated as glitches.
- `THRESH`, 12500: periods shorter than this are a 1 bit; periods from this value up to `MAX_PERIOD` are a 0 bit.
- `MAX_PERIOD`, 40000: periods longer than this are a timeout/idle.
- `FIFO_AW`, 4: FIFO depth is 2^FIFO_AW bytes.

Ports:
- `clk`  in  1: system clock (`clk_sys`).
- `reset`  in  1: asynchronous, active-high reset.
- `enable`  in  1: capture enable. While low, the framer is held in IDLE and no pushes occur.
- `tape_in`  in  1: raw tape output level, asynchronous to `clk`.
- `rd`  in  1: pops the FIFO head. Ignored when empty.
- `dout`  out  8: FIFO head byte; valid while `empty` is 0.
- `empty`  out  1: FIFO empty.
- `level`  out  FIFO_AW+1: FIFO occupancy.
- `byte_cnt`  out  16: bytes decoded since reset; wraps.
- `parity_err`  out  1: sticky; a byte failed the parity check.
- `overflow`  out  1: sticky; a byte was dropped because the FIFO was full.
- `active`  out  1: the framer is not in IDLE.
- `clr_flags`  in  1: synchronous clear of `parity_err`, `overflow` and `byte_cnt`.

## Operation

Input conditioning:
- `tape_in` passes through a 2-flop synchronizer.
- A rising edge is detected on the synchronized level.

Period counter:
- 16 bits, increments every clock and saturates at 16'hFFFF.
- On an accepted edge it reloads to 1.

Edge classification, using the counter value P at the edge:
- P < `MIN_PERIOD`: glitch. The edge is ignored and the counter is not reset.
- P < `THRESH`: bit 1.
- P <= `MAX_PERIOD`: bit 0.
- P > `MAX_PERIOD`: timeout. The framer goes to IDLE, no bit is emitted, and the counter reloads.
- Independently of edges, the counter reaching `MAX_PERIOD`+1 also forces the framer to IDLE.

Framer FSM (Oric byte: start 0, 8 data bits LSB first, odd parity, stop 1s):
- IDLE: a 0 bit goes to DATA and clears the bit index. A 1 bit stays in IDLE; stop and leader bits are absorbed here.
- DATA: each bit shifts in LSB first. After the 8th bit, go to PARITY.
- PARITY: on the bit, compute the check; the total count of 1s in data plus parity must be odd. Push the byte (even on error), set `parity_err` on error, increment `byte_cnt`, and return to IDLE.

Control and boundaries:
- `enable` low forces IDLE and discards any partial byte; the FIFO is untouched.
- FIFO full at push time:
  - Without a simultaneous `rd`, the byte is dropped and `overflow` is set. `byte_cnt` still increments.
  - With a simultaneous `rd`, the pop and the push both occur and `level` stays unchanged.
- `rd` while empty is a no-op.
- Push into an empty FIFO with a simultaneous `rd`: the `rd` is ignored and the byte is stored.
- Reset mid-byte clears the framer, FIFO and flags; there is no partial recovery.

## Timing

- Reset values:
  - `dout` = 0.
  - `empty` = 1.
  - `level` = 0.
  - `byte_cnt` = 0.
  - `parity_err` = 0.
  - `overflow` = 0.
  - `active` = 0.
  - FSM in IDLE; period counter saturated (so the first edge reads as a timeout).
- Latency: a `tape_in` rising edge reaches bit classification 3 clocks later (2 synchronizer clocks plus 1 edge-register clock).
- The pushed byte appears on `dout` with `empty` low 1 clock after the parity bit is classified.
- `rd` registered at edge N: the next head byte is on `dout` at N+1, and `level` updates at N+1.
- `clr_flags` takes effect on the next clock. If it coincides with a push, the push wins for `byte_cnt` (result is 1).

## Configuration

- `TAPE_CAPTURE_PARITY_EN` defined: parity is checked and `parity_err` is produced as described above.
- Not defined:
  - The parity bit is still consumed, so framing is identical.
  - `parity_err` is tied to 0 and no checker logic is generated.

## Test plan

Bench parameters: `MIN_PERIOD`=4, `THRESH`=12, `MAX_PERIOD`=24, `FIFO_AW`=2, macro defined.

- **Single byte:**
  - Stimulus: periods 8 (leader 1s), 16 (start), byte 8'hA5 LSB first (1=8, 0=16), parity 1 (odd: four 1s plus parity).
  - Required: `dout`=8'hA5, `empty`=0, `byte_cnt`=1, `parity_err`=0.
- **Parity error:** same byte with parity bit 0 → byte pushed, `parity_err`=1; `clr_flags` → `parity_err`=0, `byte_cnt`=0.
- **Glitch immunity:** insert a 2-clock pulse mid-bit in a 16-clock 0 period → decoded byte unchanged.
- **Timeout:** after 4 data bits, hold `tape_in` low for 30 clocks → `active`=0, nothing pushed. The next valid frame 8'h3C decodes correctly.
- **Overflow:**
  - Stimulus: 5 bytes (8'h01–8'h05) with no reads.
  - Required: `level`=4, `overflow`=1, `byte_cnt`=5; reads return 01, 02, 03, 04 and then `empty`=1.
- **Full plus simultaneous read:** with the FIFO full, assert `rd` in the push cycle → `level` stays 4, `overflow`=0, tail byte equals the new byte.
